// File: rtl/wb_mem_arbiter_pkg.sv
// wb_mem_arbiter_pkg: shared Wishbone cycle-type codes and arbiter state encoding.
package wb_mem_arbiter_pkg;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
endpackage

// File: rtl/wb_mem_arbiter_if.sv
// wb_mem_arbiter_if: bundled master-side (NM packed lanes) and slave-side Wishbone B3 signals.
interface wb_mem_arbiter_if #(parameter int NM = 3, parameter int AW = 32, parameter int DW = 32);
    logic [NM*AW-1:0]   m_adr_i;
    logic [NM*DW-1:0]   m_dat_i;
    logic [NM*DW/8-1:0] m_sel_i;
    logic [NM-1:0]      m_we_i;
    logic [NM-1:0]      m_cyc_i;
    logic [NM-1:0]      m_stb_i;
    logic [NM*3-1:0]    m_cti_i;
    logic [NM*2-1:0]    m_bte_i;
    logic [DW-1:0]      m_dat_o;
    logic [NM-1:0]      m_ack_o;
    logic [NM-1:0]      m_err_o;
    logic [NM-1:0]      m_rty_o;
    logic [AW-1:0]      s_adr_o;
    logic [DW-1:0]      s_dat_o;
    logic [DW/8-1:0]    s_sel_o;
    logic               s_we_o;
    logic               s_cyc_o;
    logic               s_stb_o;
    logic [2:0]         s_cti_o;
    logic [1:0]         s_bte_o;
    logic [DW-1:0]      s_dat_i;
    logic               s_ack_i;
    logic               s_err_i;
    logic               s_rty_i;
    // The arbiter masters the RAM port; the surrounding masters and RAM form the slave view.
    modport master (
        input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
        input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
        output m_dat_o, m_ack_o, m_err_o, m_rty_o,
        output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o
    );
    modport slave (
        output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
        output s_dat_i, s_ack_i, s_err_i, s_rty_i,
        input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
        input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o
    );
endinterface

// File: rtl/wb_mem_arbiter_rr_pick.sv
// wb_rr_pick: combinational round-robin picker; first requester above the one-hot last grant, wrapping.
module wb_rr_pick #(parameter int NM = 3) (
    input  logic [NM-1:0] req,
    input  logic [NM-1:0] last,
    output logic [NM-1:0] nxt
);
    logic [NM-1:0] hi, r;
    // Bits strictly above last; empty when last is the MSB, which gives the wrap to bit 0.
    assign hi  = req & ~((last << 1) - {{(NM-1){1'b0}}, 1'b1});
    assign r   = |hi ? hi : req;
    assign nxt = r & (~r + {{(NM-1){1'b0}}, 1'b1});
endmodule

// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: round-robin Wishbone B3 arbiter for the shared RAM port; grant held for a whole cyc.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that ends hung cycles with err after TIMEOUT_CYCLES.
module wb_mem_arbiter
    import wb_mem_arbiter_pkg::*;
#(
    parameter int NM             = 3,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    wb_mem_arbiter_if.master      bus,
    output logic [NM-1:0]         grant_o
);
    state_t        state, state_nxt;
    logic [NM-1:0] last, last_nxt, grant_nxt, pick;
    logic          gcyc, gstb, tmo;

    if (NM < 2 || NM > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("wb_mem_arbiter: unsupported NM or TIMEOUT_CYCLES");
    end

    assign gcyc = |(grant_o & bus.m_cyc_i);
    assign gstb = |(grant_o & bus.m_stb_i);

    wb_rr_pick #(.NM(NM)) u_pick (.req(bus.m_cyc_i), .last(last), .nxt(pick));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= ST_IDLE;
            grant_o <= '0;
            last    <= {1'b1, {(NM-1){1'b0}}};
        end else begin
            state   <= state_nxt;
            grant_o <= grant_nxt;
            last    <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_o;
        last_nxt  = last;
        if (state == ST_IDLE) begin
            if (|bus.m_cyc_i) begin
                state_nxt = ST_BUSY;
                grant_nxt = pick;
                last_nxt  = pick;
            end
        end else if (!gcyc || tmo) begin
            state_nxt = ST_IDLE;
            grant_nxt = '0;
        end
    end

    // Grant is zero in IDLE, so the AND-OR mux drives all slave-side outputs low there.
    always_comb begin
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_sel_o = '0;
        bus.s_cti_o = '0;
        bus.s_bte_o = '0;
        for (int k = 0; k < NM; k++) begin
            if (grant_o[k]) begin
                bus.s_adr_o = bus.s_adr_o | bus.m_adr_i[k*AW +: AW];
                bus.s_dat_o = bus.s_dat_o | bus.m_dat_i[k*DW +: DW];
                bus.s_sel_o = bus.s_sel_o | bus.m_sel_i[k*(DW/8) +: DW/8];
                bus.s_cti_o = bus.s_cti_o | bus.m_cti_i[k*3 +: 3];
                bus.s_bte_o = bus.s_bte_o | bus.m_bte_i[k*2 +: 2];
            end
        end
        bus.s_we_o  = |(grant_o & bus.m_we_i);
        bus.s_cyc_o = gcyc & ~tmo;
        bus.s_stb_o = gstb & ~tmo;
        bus.m_ack_o = grant_o & {NM{bus.s_ack_i}};
        bus.m_err_o = grant_o & {NM{bus.s_err_i | tmo}};
        bus.m_rty_o = grant_o & {NM{bus.s_rty_i}};
    end

    assign bus.m_dat_o = bus.s_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    assign tmo = (state == ST_BUSY) && (tmo_cnt == TW'(TIMEOUT_CYCLES));
    always_ff @(posedge wb_clk_i) begin
        tmo_cnt <= (wb_rst_i || state != ST_BUSY || tmo || bus.s_ack_i || bus.s_err_i || bus.s_rty_i)
                   ? '0 : tmo_cnt + TW'(gstb);
    end
`else
    assign tmo = 1'b0;
`endif
endmodule
